// File: rtl/pwm_duty_uart_tx_if.sv
// Signal bundle between the duty-cycle meter and whatever drives/observes it.
// The meter is the slave: it takes enable and the PWM input, and returns the
// serial line plus measurement status.
interface pwm_duty_uart_tx_if;
  logic       en;
  logic       pwm_in;
  logic       uart_txd;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output en,
    output pwm_in,
    input  uart_txd,
    input  sample,
    input  sample_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  en,
    input  pwm_in,
    output uart_txd,
    output sample,
    output sample_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/pwm_duty_uart_tx.sv
// PWM duty-cycle meter with UART 8N1 read-back.
// Counts synchronized high cycles over a 2^WINDOW_LOG2-clock window, scales the
// count to one byte and sends it on uart_txd. A byte that arrives while a frame
// is on the line is kept in `sample` but not sent, and `overrun` flags it.
//
// TX state | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle high, waiting for a new sample
// S_START  | start bit (low) for one bit time
// S_DATA   | 8 data bits, LSB first, one bit time each
// S_STOP   | stop bit (high) for one bit time, then idle
module pwm_duty_uart_tx #(
  parameter int WINDOW_LOG2  = 13,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk1,
  input  logic                 rst,
  pwm_duty_uart_tx_if.slave    bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Synchronizer; p_q is the only view of pwm_in the counters ever see.
  logic p_meta_q;
  logic p_q;

  logic [WINDOW_LOG2-1:0] w_q, w_d;
  logic [WINDOW_LOG2:0]   h_q, h_d;
  logic [WINDOW_LOG2:0]   total;
  logic [7:0]             sample_q, sample_d;
  logic [7:0]             meas_byte;
  logic                   sv_q, sv_d;
  logic                   win_end;

  tx_state_t   state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;
  logic        busy_q;
  logic        ovr_q;
  logic        bit_done;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      p_meta_q <= 1'b0;
      p_q      <= 1'b0;
    end else begin
      p_meta_q <= bus.pwm_in;
      p_q      <= p_meta_q;
    end
  end

  // Window/high counter next state; the last window cycle's p is folded into
  // the total so every one of the 2^WINDOW_LOG2 cycles is counted.
  always_comb begin
    total     = h_q + {{WINDOW_LOG2{1'b0}}, p_q};
    win_end   = bus.en && (w_q == '1);
    meas_byte = total[WINDOW_LOG2] ? 8'hFF : 8'(total >> (WINDOW_LOG2 - 8));
    w_d       = w_q;
    h_d       = h_q;
    sample_d  = sample_q;
    sv_d      = 1'b0;
    if (!bus.en) begin
      w_d = '0;
      h_d = '0;
    end else if (win_end) begin
      w_d      = '0;
      h_d      = '0;
      sample_d = meas_byte;
      sv_d     = 1'b1;
    end else begin
      w_d = w_q + WINDOW_LOG2'(1);
      h_d = total;
    end
  end

  // Measurement registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      w_q      <= '0;
      h_q      <= '0;
      sample_q <= 8'h00;
      sv_q     <= 1'b0;
    end else begin
      w_q      <= w_d;
      h_q      <= h_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
    end
  end

  assign bit_done = (baud_q == BAUD_LAST);

  // UART transmitter; start bit is driven on the same edge the sample lands.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= sv_d && (state_q != S_IDLE);
      if (state_q != S_IDLE) begin
        baud_q <= bit_done ? '0 : baud_q + BAUD_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (sv_d) begin
            shift_q <= meas_byte;
            state_q <= S_START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            state_q <= S_DATA;
            bit_q   <= 3'd0;
            txd_q   <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end
        end
        S_STOP: begin
          if (bit_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uart_txd     = txd_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sv_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_pwm_duty_uart_tx.sv
// Directed bench for the duty-cycle meter: one instance at the default
// window/baud, one small instance (256-clock window, 100-clock bits) where
// frames outlast windows.
module tb_pwm_duty_uart_tx;
  logic clk1 = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pwm_duty_uart_tx_if ifa ();
  pwm_duty_uart_tx_if ifb ();

  pwm_duty_uart_tx #(.WINDOW_LOG2(13), .CLKS_PER_BIT(434)) dut_a (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (ifa)
  );

  pwm_duty_uart_tx #(.WINDOW_LOG2(8), .CLKS_PER_BIT(100)) dut_b (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (ifb)
  );

  always #5 clk1 = ~clk1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic get_txd(input bit which);
    return which ? ifb.uart_txd : ifa.uart_txd;
  endfunction
  function automatic logic get_busy(input bit which);
    return which ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic get_sv(input bit which);
    return which ? ifb.sample_valid : ifa.sample_valid;
  endfunction
  function automatic logic get_ov(input bit which);
    return which ? ifb.overrun : ifa.overrun;
  endfunction

  // Fresh window on instance A (en must be low on entry). pwm_in is driven so
  // that, after the 2-clock synchronizer, exactly hi_len of the window's
  // cycles see p=1: the value driven before edge j is counted at edge j+2,
  // and the window spans enabled edges 1..8192, so drives j=-1..hi_len-2 are high.
  task automatic run_window(input int hi_len, output int n, output logic [7:0] s);
    ifa.pwm_in = (hi_len >= 1);
    tick();
    ifa.pwm_in = (hi_len >= 2);
    tick();
    ifa.en     = 1'b1;
    ifa.pwm_in = (hi_len >= 3);
    n = 0;
    s = 8'h00;
    for (int i = 1; i <= 9000; i++) begin
      tick();
      n = i;
      ifa.pwm_in = ((i + 1) <= (hi_len - 2));
      if (ifa.sample_valid) begin
        s = ifa.sample;
        break;
      end
    end
  endtask

  // Called at the first observation after the start-bit edge. Records each
  // bit from its first cycle, flags any change within a bit time, and counts
  // busy cycles plus later sample_valid/overrun pulses until busy drops.
  task automatic rx_frame(input bit which, input int cpb, output logic [9:0] bits,
                          output int len, output bit stable, output int svc, output int ovc);
    int idx;
    bits   = '0;
    len    = 0;
    stable = 1'b1;
    svc    = 0;
    ovc    = 0;
    for (int i = 0; i < 12 * cpb; i++) begin
      if (!get_busy(which)) break;
      if (i > 0 && get_sv(which)) svc++;
      if (get_ov(which)) ovc++;
      idx = i / cpb;
      if (idx < 10) begin
        if ((i % cpb) == 0) bits[idx] = get_txd(which);
        else if (get_txd(which) !== bits[idx]) stable = 1'b0;
      end
      len++;
      tick();
    end
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] s;
    int         n, m, len, svc, ovc;
    bit         stable;

    rst        = 1'b1;
    ifa.en     = 1'b0;
    ifa.pwm_in = 1'b0;
    ifb.en     = 1'b0;
    ifb.pwm_in = 1'b1;
    tick();
    tick();
    check_val("rst_txd",    ifa.uart_txd, 1);
    check_val("rst_busy",   ifa.busy, 0);
    check_val("rst_sample", ifa.sample, 0);
    check_val("rst_sv",     ifa.sample_valid, 0);
    check_val("rst_ovr",    ifa.overrun, 0);

    // All-high input straight out of reset; first two cycles are lost to the
    // synchronizer flops, 8190 still saturates to 0xFF.
    ifa.en     = 1'b1;
    ifa.pwm_in = 1'b1;
    rst        = 1'b0;
    n = 0;
    for (int i = 1; i <= 9000; i++) begin
      tick();
      n = i;
      if (ifa.sample_valid) break;
    end
    check_val("first_sv_latency", n, 8192);
    check_val("high_sample", ifa.sample, 8'hFF);
    check_val("high_ovr", ifa.overrun, 0);
    check_val("start_busy", ifa.busy, 1);
    check_val("start_txd", ifa.uart_txd, 0);
    rx_frame(1'b0, 434, bits, len, stable, svc, ovc);
    check_val("high_bits", bits, {1'b1, 8'hFF, 1'b0});
    check_val("high_len", len, 4340);
    check_val("high_stable", stable, 1);
    check_val("high_frame_ovr", ovc, 0);
    ifa.en = 1'b0;

    // 25% duty aligned to the window.
    run_window(2048, n, s);
    check_val("q25_period", n, 8192);
    check_val("q25_sample", s, 8'h40);
    rx_frame(1'b0, 434, bits, len, stable, svc, ovc);
    check_val("q25_bits", bits, {1'b1, 8'h40, 1'b0});
    check_val("q25_len", len, 4340);
    check_val("q25_stable", stable, 1);
    ifa.en = 1'b0;

    run_window(0, n, s);
    check_val("zero_period", n, 8192);
    check_val("zero_sample", s, 8'h00);
    ifa.en = 1'b0;

    // Partial all-high window abandoned at w=4000 must not leak into the next.
    ifa.pwm_in = 1'b1;
    ifa.en     = 1'b1;
    svc = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (ifa.sample_valid) svc++;
    end
    ifa.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.sample_valid) svc++;
    end
    check_val("partial_no_sv", svc, 0);
    run_window(4128, n, s);
    check_val("reen_period", n, 8192);
    check_val("reen_sample", s, 8'h81);
    ifa.en = 1'b0;

    run_window(33, n, s);
    check_val("b33_period", n, 8192);
    check_val("b33_sample", s, 8'h01);
    ifa.en = 1'b0;

    // 8191 highs: just below saturation, truncates to 255.
    run_window(8191, n, s);
    check_val("b8191_period", n, 8192);
    check_val("b8191_sample", s, 8'hFF);
    for (int i = 0; i < 500; i++) tick();
    check_val("midframe_busy", ifa.busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_txd", ifa.uart_txd, 1);
    check_val("async_rst_busy", ifa.busy, 0);
    check_val("async_rst_sample", ifa.sample, 0);
    ifa.en     = 1'b1;
    ifa.pwm_in = 1'b1;
    rst        = 1'b0;
    n = 0;
    for (int i = 1; i <= 9000; i++) begin
      tick();
      n = i;
      if (ifa.sample_valid) break;
    end
    check_val("post_rst_latency", n, 8192);
    check_val("post_rst_sample", ifa.sample, 8'hFF);
    ifa.en = 1'b0;

    // Small instance: 1000-clock frames over 256-clock windows.
    ifb.en = 1'b1;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      n = i;
      if (ifb.sample_valid) break;
    end
    check_val("b_first_sv", n, 256);
    check_val("b_sample", ifb.sample, 8'hFF);
    check_val("b_first_ovr", ifb.overrun, 0);
    rx_frame(1'b1, 100, bits, len, stable, svc, ovc);
    check_val("b_bits", bits, {1'b1, 8'hFF, 1'b0});
    check_val("b_len", len, 1000);
    check_val("b_stable", stable, 1);
    check_val("b_sv_in_frame", svc, 3);
    check_val("b_ovr_in_frame", ovc, 3);
    check_val("b_sample_kept", ifb.sample, 8'hFF);
    m = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      m = i;
      if (ifb.sample_valid) break;
    end
    check_val("b_next_sv_gap", m, 24);
    check_val("b_next_busy", ifb.busy, 1);
    check_val("b_next_ovr", ifb.overrun, 0);
    ifb.en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
